// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
//   arb_state_t : burst-lock FSM states (used only when FIFO_WR_ARB_LOCK_EN is defined)
//   idx_w()     : index width for a count of n items, never less than 1
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker.
// Returns the first set bit of req, scanning upward from index start and wrapping.
//   req   in  N   request vector
//   start in  IW  index with highest priority (must be < N)
//   grant out IW  picked index (0 when nothing requested)
//   valid out 1   any request present
module rr_priority_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] grant,
  output logic          valid
);

  // Scan from lowest to highest priority so the highest-priority hit is
  // the last assignment; avoids a separate found flag.
  always_comb begin
    int s;
    grant = '0;
    valid = 1'b0;
    s     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      s = int'(start) + k;
      if (s >= N) s = s - N;
      if (req[IW'(s)]) begin
        grant = IW'(s);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one buffer write port among NUM_REQ producers.
// Grants are combinational; at most one word is accepted per clock, and no
// write is issued while the buffer reports full.
//
// Optional feature macro: FIFO_WR_ARB_LOCK_EN
//   defined   : a producer granted with lock[i]=1 keeps ownership for up to
//               MAX_BURST consecutive writes (ARB_IDLE / ARB_LOCKED FSM).
//   undefined : lock is ignored, pure round-robin.
//
// Ports
//   clk, reset        clock (rising), asynchronous active-high reset
//   req[i]            producer i has a word pending
//   lock[i]           producer i asks for burst ownership
//   wdata             flat words, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ack[i]            one-hot, word i accepted this cycle
//   fifo_full         full flag from buffer controller
//   fifo_wr           write strobe to buffer controller
//   fifo_wdata        granted word (0 when nothing requested)
//   grant_id          index of current grant (valid with fifo_wr)
//   wr_count          accepted writes, wraps
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            lock,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          fifo_full,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic [CNT_WIDTH-1:0]          wr_count
);

  localparam int IW = idx_w(NUM_REQ);

  logic [IW-1:0]      last_grant;
  logic [IW-1:0]      start;
  logic [IW-1:0]      grant;
  logic               any_req;
  logic [NUM_REQ-1:0] eff_req;

  assign start = (int'(last_grant) == NUM_REQ - 1) ? '0 : last_grant + IW'(1);

  rr_priority_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req   (eff_req),
    .start (start),
    .grant (grant),
    .valid (any_req)
  );

  // Reset also blocks the strobe so a pending word is never acked while
  // the arbiter is being reset.
  assign fifo_wr    = any_req & ~fifo_full & ~reset;
  assign ack        = fifo_wr ? (NUM_REQ'(1) << grant) : '0;
  assign grant_id   = grant;
  assign fifo_wdata = any_req ? wdata[grant*DATA_WIDTH +: DATA_WIDTH] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= IW'(NUM_REQ - 1);
      wr_count   <= '0;
    end else if (fifo_wr) begin
      last_grant <= grant;
      wr_count   <= wr_count + CNT_WIDTH'(1);
    end
  end

`ifdef FIFO_WR_ARB_LOCK_EN
  localparam int BW = idx_w(MAX_BURST + 1);

  arb_state_t    state, state_nx;
  logic [IW-1:0] owner, owner_nx;
  logic [BW-1:0] burst_cnt, burst_nx;
  logic          hold;

  // Ownership only masks others while the owner still requests; once the
  // owner drops req the cycle falls straight back to round-robin.
  assign hold = (state == ARB_LOCKED) && req[owner];

  always_comb begin
    eff_req = req;
    if (hold) eff_req = NUM_REQ'(1) << owner;
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    burst_nx = burst_cnt;
    if (!fifo_full) begin
      if (hold) begin
        // hold with !full implies an owner write this cycle
        if (!lock[owner] || (int'(burst_cnt) + 1 == MAX_BURST)) begin
          state_nx = ARB_IDLE;
          burst_nx = '0;
        end else begin
          burst_nx = burst_cnt + BW'(1);
        end
      end else begin
        state_nx = ARB_IDLE;
        burst_nx = '0;
        if (fifo_wr && lock[grant] && (MAX_BURST > 1)) begin
          state_nx = ARB_LOCKED;
          owner_nx = grant;
          burst_nx = BW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ARB_IDLE;
      owner     <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nx;
      owner     <= owner_nx;
      burst_cnt <= burst_nx;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock ^ (MAX_BURST > 1);
  assign eff_req     = req;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req, lock;
  logic [N*DW-1:0] wdata;
  logic            fifo_full;

  logic [N-1:0]    ack, ack4;
  logic            fifo_wr, fifo_wr4;
  logic [DW-1:0]   fifo_wdata, fifo_wdata4;
  logic [1:0]      grant_id, grant_id4;
  logic [15:0]     wr_count;
  logic [3:0]      wr_count4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(4), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .wdata(wdata), .ack(ack),
    .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata),
    .grant_id(grant_id), .wr_count(wr_count)
  );

  // Narrow-counter copy for wrap checking; shares all inputs.
  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(4), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .wdata(wdata), .ack(ack4),
    .fifo_full(fifo_full), .fifo_wr(fifo_wr4), .fifo_wdata(fifo_wdata4),
    .grant_id(grant_id4), .wr_count(wr_count4)
  );

  // Every task begins and ends 1 time unit after a rising edge.
  task automatic do_reset();
    reset = 1'b1; req = '0; lock = '0; fifo_full = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; lock = '0; fifo_full = 1'b0; wdata = '0;
    #3;
    checks++;
    if (ack !== 4'b0000 || fifo_wr !== 1'b0 || grant_id !== 2'd0 || fifo_wdata !== 8'h00 || wr_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b wr=%b gid=%0d data=%h cnt=%0d, expected 0000 0 0 00 0",
               ack, fifo_wr, grant_id, fifo_wdata, wr_count);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [N-1:0]  exp_ack;
    logic [DW-1:0] exp_data;
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111; fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_ack  = 4'b0001 << i;
      exp_data = 8'(8'h11 * (i + 1));
      checks++;
      if (ack !== exp_ack || fifo_wr !== 1'b1) begin
        errors++;
        $display("FAIL rr_ack[%0d]: ack=%b wr=%b, expected ack=%b wr=1", i, ack, fifo_wr, exp_ack);
      end
      checks++;
      if (fifo_wdata !== exp_data || grant_id !== 2'(i)) begin
        errors++;
        $display("FAIL rr_data[%0d]: data=%h gid=%0d, expected data=%h gid=%0d", i, fifo_wdata, grant_id, exp_data, i);
      end
      @(posedge clk); #1;
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (wr_count !== 16'd4 || fifo_wr !== 1'b0 || fifo_wdata !== 8'h00) begin
      errors++;
      $display("FAIL rr_count: cnt=%0d wr=%b data=%h, expected cnt=4 wr=0 data=00", wr_count, fifo_wr, fifo_wdata);
    end
    @(posedge clk); #1;
  endtask

  // last_grant=3 on entry; one write from req0 makes last_grant=0.
  task automatic test_sparse_req();
    logic [N-1:0] exp_seq [3];
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0100; exp_seq[2] = 4'b0001;
    wdata = {8'h44, 8'hA5, 8'h22, 8'h5A};
    for (int i = 0; i < 3; i++) begin
      req = (i == 0) ? 4'b0001 : 4'b0101;
      @(negedge clk);
      checks++;
      if (ack !== exp_seq[i]) begin
        errors++;
        $display("FAIL sparse_ack[%0d]: ack=%b, expected %b", i, ack, exp_seq[i]);
      end
      if (i == 1) begin
        checks++;
        if (fifo_wdata !== 8'hA5) begin
          errors++;
          $display("FAIL sparse_data: data=%h, expected a5", fifo_wdata);
        end
      end
      @(posedge clk); #1;
    end
    req = '0;
  endtask

  // last_grant=0 on entry, wr_count=7.
  task automatic test_full();
    req = 4'b1111; fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ack !== 4'b0000 || fifo_wr !== 1'b0) begin
        errors++;
        $display("FAIL full_block[%0d]: ack=%b wr=%b, expected 0000 0", i, ack, fifo_wr);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (wr_count !== 16'd7) begin
      errors++;
      $display("FAIL full_count: cnt=%0d, expected 7", wr_count);
    end
    fifo_full = 1'b0;
    @(negedge clk);
    checks++;
    if (ack !== 4'b0010 || fifo_wr !== 1'b1 || grant_id !== 2'd1) begin
      errors++;
      $display("FAIL full_resume: ack=%b wr=%b gid=%0d, expected 0010 1 1", ack, fifo_wr, grant_id);
    end
    @(posedge clk); #1;
    req = '0;
  endtask

  task automatic test_count_wrap();
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      if (i == 14) begin
        checks++;
        if (wr_count4 !== 4'hF) begin
          errors++;
          $display("FAIL wrap_max: cnt4=%0d, expected 15", wr_count4);
        end
      end
    end
    req = '0;
    checks++;
    if (wr_count4 !== 4'd1 || wr_count !== 16'd17) begin
      errors++;
      $display("FAIL wrap_count: cnt4=%0d cnt=%0d, expected 1 17", wr_count4, wr_count);
    end
  endtask

`ifdef FIFO_WR_ARB_LOCK_EN
  task automatic test_lock_burst();
    logic [N-1:0] exp_ack;
    do_reset();
    req = 4'b0011; lock = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      exp_ack = (i < 4) ? 4'b0001 : 4'b0010;
      @(negedge clk);
      checks++;
      if (ack !== exp_ack) begin
        errors++;
        $display("FAIL lock_burst[%0d]: ack=%b, expected %b", i, ack, exp_ack);
      end
      @(posedge clk); #1;
    end
    req = '0; lock = '0;
  endtask

  task automatic test_lock_drop();
    logic [N-1:0] exp_seq [3];
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0001; exp_seq[2] = 4'b0010;
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      lock = (i == 0) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      checks++;
      if (ack !== exp_seq[i]) begin
        errors++;
        $display("FAIL lock_drop[%0d]: ack=%b, expected %b", i, ack, exp_seq[i]);
      end
      @(posedge clk); #1;
    end
    req = '0;
  endtask
`else
  task automatic test_lock_ignored();
    logic [N-1:0] exp_ack;
    do_reset();
    req = 4'b0011; lock = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      exp_ack = (i % 2 == 0) ? 4'b0001 : 4'b0010;
      @(negedge clk);
      checks++;
      if (ack !== exp_ack) begin
        errors++;
        $display("FAIL lock_ignored[%0d]: ack=%b, expected %b", i, ack, exp_ack);
      end
      @(posedge clk); #1;
    end
    req = '0; lock = '0;
  endtask
`endif

  task automatic test_reset_mid_burst();
    do_reset();
    req = 4'b0011; lock = 4'b0001;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (wr_count !== 16'd2) begin
      errors++;
      $display("FAIL midrst_pre: cnt=%0d, expected 2", wr_count);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (ack !== 4'b0000 || fifo_wr !== 1'b0 || wr_count !== 16'd0) begin
      errors++;
      $display("FAIL midrst_async: ack=%b wr=%b cnt=%0d, expected 0000 0 0", ack, fifo_wr, wr_count);
    end
    @(negedge clk);
    reset = 1'b0; req = 4'b1111; lock = '0;
    #1;
    checks++;
    if (ack !== 4'b0001 || wr_count !== 16'd0) begin
      errors++;
      $display("FAIL midrst_after: ack=%b cnt=%0d, expected 0001 0", ack, wr_count);
    end
    @(posedge clk); #1;
    req = '0;
  endtask

  initial begin
    reset = 1'b1; req = '0; lock = '0; wdata = '0; fifo_full = 1'b0;
    #1;
    test_reset();
    test_round_robin();
    test_sparse_req();
    test_full();
    test_count_wrap();
`ifdef FIFO_WR_ARB_LOCK_EN
    test_lock_burst();
    test_lock_drop();
`else
    test_lock_ignored();
`endif
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
